dds_loader: RTL

Host-side control and load sequencer for the multi-channel DDS core. It holds a shadow table of per-channel phase (theta), phase increment (delta) and amplitude words written by the host. On a commit it resets the DDS, serialises the table into the three DDS circulating shift-register FIFOs through the DDS address/data port, and then asserts start so that the channels free-run. It sits between the AXI register slave and the DDS core, and is the only driver of the DDS `i_dds_rst`, `i_dds_start`, `i_dds_addrs` and `i_dds_fifo_data` inputs.

---
 rtl/dds_loader.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dds_loader.sv
// Load sequencer for the multi-channel DDS: holds the host shadow table and, on
// commit, resets the DDS, streams theta/delta/ampl into its FIFOs, then starts it.
module dds_loader #(
  parameter int         SIG_WIDTH = 16,
  parameter int         N_CH      = 8,
  parameter int         CH_W      = $clog2(N_CH),
  parameter logic [8:0] PARK_ADDR = 9'd511
) (
  input  logic                 clk,
  input  logic                 a_rst_n,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  input  logic [CH_W-1:0]      i_wr_ch,
  input  logic [1:0]           i_wr_field,
  input  logic [SIG_WIDTH-1:0] i_wr_data,
  input  logic                 i_commit,
  input  logic                 i_stop,
  output logic                 o_dds_rst,
  output logic                 o_dds_start,
  output logic [8:0]           o_dds_addrs,
  output logic [SIG_WIDTH-1:0] o_dds_fifo_data,
  output logic                 o_busy,
  output logic                 o_running
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_LOAD_T,
    S_LOAD_D,
    S_LOAD_A,
    S_RUN
  } state_e;

  localparam logic [CH_W-1:0] LAST_K = CH_W'(N_CH - 1);

  state_e               state_q, state_d;
  logic [CH_W-1:0]      cnt_q, cnt_d;
  logic                 abort;

  logic [SIG_WIDTH-1:0] theta_q [N_CH];
  logic [SIG_WIDTH-1:0] delta_q [N_CH];
  logic [SIG_WIDTH-1:0] ampl_q  [N_CH];

  logic                 rst_q, rst_d;
  logic                 start_q, start_d;
  logic [8:0]           addrs_q, addrs_d;
  logic [SIG_WIDTH-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 running_q, running_d;

  logic                 wr_fire;
  logic                 wr_in_range;

  assign wr_fire     = i_wr_valid & ready_q;
  assign wr_in_range = int'(i_wr_ch) < N_CH;

  // Out-of-range channels and the reserved field are acknowledged but dropped.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        theta_q[CH_W'(i)] <= '0;
        delta_q[CH_W'(i)] <= '0;
        ampl_q[CH_W'(i)]  <= '0;
      end
    end else if (wr_fire && wr_in_range) begin
      case (i_wr_field)
        2'd0:    theta_q[i_wr_ch] <= i_wr_data;
        2'd1:    delta_q[i_wr_ch] <= i_wr_data;
        2'd2:    ampl_q[i_wr_ch]  <= i_wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stop has priority over commit everywhere; in RST/LOAD it aborts with a DDS reset pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_commit && !i_stop) begin
          state_d = S_RST;
          cnt_d   = '0;
        end
      end
      S_RST: begin
        cnt_d = '0;
        if (i_stop) begin
          state_d = S_IDLE;
          abort   = 1'b1;
        end else begin
          state_d = S_LOAD_T;
        end
      end
      S_LOAD_T, S_LOAD_D, S_LOAD_A: begin
        if (i_stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == LAST_K) begin
          cnt_d = '0;
          case (state_q)
            S_LOAD_T: state_d = S_LOAD_D;
            S_LOAD_D: state_d = S_LOAD_A;
            default:  state_d = S_RUN;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (i_stop) begin
          state_d = S_IDLE;
        end else if (i_commit) begin
          state_d = S_RST;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every port is a flop.
  always_comb begin
    rst_d     = (state_d == S_RST) | abort;
    start_d   = (state_d == S_RUN);
    running_d = (state_d == S_RUN);
    ready_d   = (state_d == S_IDLE) || (state_d == S_RUN);
    busy_d    = !ready_d;
    addrs_d   = PARK_ADDR;
    data_d    = '0;
    case (state_d)
      S_LOAD_T: begin
        addrs_d = 9'd0;
        data_d  = theta_q[cnt_d];
      end
      S_LOAD_D: begin
        addrs_d = 9'd1;
        data_d  = delta_q[cnt_d];
      end
      S_LOAD_A: begin
        addrs_d = 9'd2;
        data_d  = ampl_q[cnt_d];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      rst_q     <= 1'b0;
      start_q   <= 1'b0;
      addrs_q   <= PARK_ADDR;
      data_q    <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      rst_q     <= rst_d;
      start_q   <= start_d;
      addrs_q   <= addrs_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      running_q <= running_d;
    end
  end

  assign o_dds_rst       = rst_q;
  assign o_dds_start     = start_q;
  assign o_dds_addrs     = addrs_q;
  assign o_dds_fifo_data = data_q;
  assign o_wr_ready      = ready_q;
  assign o_busy          = busy_q;
  assign o_running       = running_q;

endmodule
